// File: rtl/grey_decode_tracker_pkg.sv
// Shared defaults, tracker state encoding and a Gray-to-binary helper for the
// decode-side tracker.
package grey_decode_tracker_pkg;

  localparam int WIDTH_DEF  = 4;
  localparam int POS_W_DEF  = 16;
  localparam int ERR_W_DEF  = 8;
  localparam int GRAY_MAX_W = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    TRACK = 1'b1
  } state_t;

  // Any narrower code works when zero-extended: bit i is the XOR of all bits at
  // and above i, so the zero padding contributes nothing.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = '0;
    for (int i = 0; i < GRAY_MAX_W; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/grey_decode_tracker_if.sv
// Sample stream and tracking results between a Gray source and the tracker.
interface grey_decode_tracker_if #(
  parameter int WIDTH = 4,
  parameter int POS_W = 16,
  parameter int ERR_W = 8
);
  logic             clr;
  logic             in_valid;
  logic [WIDTH-1:0] g;
  logic             out_valid;
  logic [WIDTH-1:0] b;
  logic             step_up;
  logic             step_down;
  logic             skip_err;
  logic [POS_W-1:0] pos;
  logic [ERR_W-1:0] err_count;

  modport master (
    output clr, in_valid, g,
    input  out_valid, b, step_up, step_down, skip_err, pos, err_count
  );

  modport slave (
    input  clr, in_valid, g,
    output out_valid, b, step_up, step_down, skip_err, pos, err_count
  );
endinterface

// File: rtl/grey_decode_tracker_to_bin.sv
// Combinational Gray-to-binary decode: MSB passes through, each lower bit is
// XORed with the decoded bit above it.
module grey_to_bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] b
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign b[i] = ^g[WIDTH-1:i];
  end
endmodule

// File: rtl/grey_decode_tracker.sv
// Gray sample tracker: decodes each accepted sample, classifies the move
// against the previous one and keeps a net position and a saturating error count.
module grey_decode_tracker
  import grey_decode_tracker_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int POS_W = POS_W_DEF,
  parameter int ERR_W = ERR_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  grey_decode_tracker_if.slave bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_g_q, prev_g_d;
  logic [WIDTH-1:0] prev_b_q, prev_b_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             ov_q, ov_d;
  logic             up_q, up_d;
  logic             dn_q, dn_d;
  logic             sk_q, sk_d;

  logic [WIDTH-1:0] b_next;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] prev_b_inc;
  logic [WIDTH-1:0] prev_b_dec;
  logic             one_bit;

  grey_to_bin #(.WIDTH(WIDTH)) u_dec (
    .g (bus.g),
    .b (b_next)
  );

  assign diff       = bus.g ^ prev_g_q;
  assign one_bit    = (diff != '0) && ((diff & (diff - 1'b1)) == '0);
  assign prev_b_inc = prev_b_q + 1'b1;
  assign prev_b_dec = prev_b_q - 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      prev_g_q <= '0;
      prev_b_q <= '0;
      b_q      <= '0;
      pos_q    <= '0;
      err_q    <= '0;
      ov_q     <= 1'b0;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
      sk_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_g_q <= prev_g_d;
      prev_b_q <= prev_b_d;
      b_q      <= b_d;
      pos_q    <= pos_d;
      err_q    <= err_d;
      ov_q     <= ov_d;
      up_q     <= up_d;
      dn_q     <= dn_d;
      sk_q     <= sk_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    prev_g_d = prev_g_q;
    prev_b_d = prev_b_q;
    b_d      = b_q;
    pos_d    = pos_q;
    err_d    = err_q;
    ov_d     = 1'b0;
    up_d     = 1'b0;
    dn_d     = 1'b0;
    sk_d     = 1'b0;

    // clr wins over a same-cycle sample, which is dropped.
    if (bus.clr) begin
      state_d = EMPTY;
      pos_d   = '0;
      err_d   = '0;
    end else if (bus.in_valid) begin
      ov_d     = 1'b1;
      b_d      = b_next;
      prev_g_d = bus.g;
      prev_b_d = b_next;
      case (state_q)
        EMPTY: state_d = TRACK;
        TRACK: begin
          if (one_bit) begin
            if (b_next == prev_b_inc) begin
              up_d  = 1'b1;
              pos_d = pos_q + 1'b1;
            end else if (b_next == prev_b_dec) begin
              dn_d  = 1'b1;
              pos_d = pos_q - 1'b1;
            end
          end else if (diff != '0) begin
            sk_d = 1'b1;
            if (err_q != '1) err_d = err_q + 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.b         = b_q;
  assign bus.step_up   = up_q;
  assign bus.step_down = dn_q;
  assign bus.skip_err  = sk_q;
  assign bus.pos       = pos_q;
  assign bus.err_count = err_q;

endmodule

// File: tb/tb_grey_decode_tracker.sv
// Directed bench for grey_decode_tracker at WIDTH=4: vector table plus
// saturation, repeat and asynchronous-reset sequences.
module tb_grey_decode_tracker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  grey_decode_tracker_if #(.WIDTH(4), .POS_W(16), .ERR_W(8)) bus ();

  grey_decode_tracker #(.WIDTH(4), .POS_W(16), .ERR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        clr;
    logic        iv;
    logic [3:0]  g;
    logic        ov;
    logic [3:0]  b;
    logic        up;
    logic        dn;
    logic        sk;
    logic [15:0] pos;
    logic [7:0]  err;
  } vec_t;

  vec_t vec [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(v.ov));
    chk({tag, ".b"},         32'(bus.b),         32'(v.b));
    chk({tag, ".step_up"},   32'(bus.step_up),   32'(v.up));
    chk({tag, ".step_down"}, 32'(bus.step_down), 32'(v.dn));
    chk({tag, ".skip_err"},  32'(bus.skip_err),  32'(v.sk));
    chk({tag, ".pos"},       32'(bus.pos),       32'(v.pos));
    chk({tag, ".err_count"}, 32'(bus.err_count), 32'(v.err));
  endtask

  task automatic drive(input logic c, input logic iv, input logic [3:0] gv);
    bus.clr      = c;
    bus.in_valid = iv;
    bus.g        = gv;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vec_t e;
    //           clr   iv    g        ov    b      up    dn    sk    pos        err
    vec[0]  = '{1'b0, 1'b1, 4'b0111, 1'b1, 4'd5,  1'b0, 1'b0, 1'b0, 16'd0,     8'd0};
    vec[1]  = '{1'b0, 1'b1, 4'b0101, 1'b1, 4'd6,  1'b1, 1'b0, 1'b0, 16'd1,     8'd0};
    vec[2]  = '{1'b0, 1'b1, 4'b0111, 1'b1, 4'd5,  1'b0, 1'b1, 1'b0, 16'd0,     8'd0};
    vec[3]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 4'd5,  1'b0, 1'b0, 1'b0, 16'd0,     8'd0};
    vec[4]  = '{1'b0, 1'b1, 4'b0111, 1'b1, 4'd5,  1'b0, 1'b0, 1'b0, 16'd0,     8'd0};
    vec[5]  = '{1'b0, 1'b1, 4'b1000, 1'b1, 4'd15, 1'b0, 1'b0, 1'b1, 16'd0,     8'd1};
    vec[6]  = '{1'b0, 1'b1, 4'b0000, 1'b1, 4'd0,  1'b1, 1'b0, 1'b0, 16'd1,     8'd1};
    vec[7]  = '{1'b0, 1'b1, 4'b1000, 1'b1, 4'd15, 1'b0, 1'b1, 1'b0, 16'd0,     8'd1};
    vec[8]  = '{1'b0, 1'b1, 4'b0000, 1'b1, 4'd0,  1'b1, 1'b0, 1'b0, 16'd1,     8'd1};
    vec[9]  = '{1'b0, 1'b1, 4'b0011, 1'b1, 4'd2,  1'b0, 1'b0, 1'b1, 16'd1,     8'd2};
    vec[10] = '{1'b0, 1'b1, 4'b0010, 1'b1, 4'd3,  1'b1, 1'b0, 1'b0, 16'd2,     8'd2};
    vec[11] = '{1'b1, 1'b1, 4'b0001, 1'b0, 4'd3,  1'b0, 1'b0, 1'b0, 16'd0,     8'd0};
    vec[12] = '{1'b0, 1'b1, 4'b0001, 1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 16'd0,     8'd0};
    vec[13] = '{1'b0, 1'b1, 4'b0011, 1'b1, 4'd2,  1'b1, 1'b0, 1'b0, 16'd1,     8'd0};
    vec[14] = '{1'b0, 1'b1, 4'b0001, 1'b1, 4'd1,  1'b0, 1'b1, 1'b0, 16'd0,     8'd0};
    vec[15] = '{1'b0, 1'b1, 4'b0000, 1'b1, 4'd0,  1'b0, 1'b1, 1'b0, 16'hFFFF,  8'd0};
    vec[16] = '{1'b0, 1'b0, 4'b0000, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 16'hFFFF,  8'd0};

    bus.clr      = 1'b0;
    bus.in_valid = 1'b0;
    bus.g        = 4'b0000;

    // Reset state
    repeat (2) @(negedge clk);
    e = '{1'b0, 1'b0, 4'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'd0, 8'd0};
    chk_all("reset", e);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      drive(vec[i].clr, vec[i].iv, vec[i].g);
      chk_all($sformatf("vec%0d", i), vec[i]);
    end

    // Saturation: prev g is 0000, every alternating sample is a two-bit skip
    for (int i = 0; i < 300; i++) begin
      drive(1'b0, 1'b1, (i % 2 == 0) ? 4'b0011 : 4'b0000);
      if (i == 253) chk("sat.err254", 32'(bus.err_count), 32'd254);
      if (i == 254) chk("sat.err255", 32'(bus.err_count), 32'd255);
    end
    e = '{1'b0, 1'b1, 4'b0000, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 8'd255};
    chk_all("sat.end", e);

    // Repeated identical sample
    drive(1'b0, 1'b1, 4'b0000);
    e = '{1'b0, 1'b1, 4'b0000, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 8'd255};
    chk_all("repeat", e);

    // Asynchronous reset mid-stream, between clock edges
    bus.in_valid = 1'b1;
    bus.g        = 4'b0011;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    e = '{1'b0, 1'b0, 4'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'd0, 8'd0};
    chk_all("async_rst", e);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b1, 4'b0101);
    e = '{1'b0, 1'b1, 4'b0101, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 16'd0, 8'd0};
    chk_all("post_rst_first", e);
    drive(1'b0, 1'b1, 4'b0100);
    e = '{1'b0, 1'b1, 4'b0100, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 16'd1, 8'd0};
    chk_all("post_rst_up", e);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
